jpeg_quant: RTL and testbench
=============================

Name: jpeg_quant

Overview:
Encoder-side quantizer, the inverse of the decoder's dequantizer. It takes one signed DCT coefficient per handshake in row-major order and divides it by the matching quantization-table entry, rounding half away from zero. A serial restoring divider produces one quantized coefficient per handshake for the zigzag/entropy stage. Coefficient position within the 8x8 block comes from an internal 0..63 counter.

Parameters:
WIDTH_IN, 16, signed coefficient input width
WIDTH_Q, 16, unsigned quant table entry width
WIDTH_OUT, 16, signed quantized output width (saturating)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
quant_flat  input  WIDTH_Q*64  quant table, row-major, entry i at bits [(i+1)*WIDTH_Q-1 : i*WIDTH_Q]; held stable by the source
in_valid  input  1  coefficient valid
in_ready  output  1  block can accept a coefficient
in_data  input  WIDTH_IN  signed coefficient
out_valid  output  1  quantized result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH_OUT  signed quantized coefficient
out_index  output  6  block position (0..63) of out_data
out_last  output  1  high with out_valid when out_index==63

Behaviour:
- Reset (async, any state): state=IDLE; index=0; in_ready=1; out_valid=0; out_data=0; out_index=0; out_last=0; divider registers cleared; any in-flight coefficient is discarded.
- DW = max(WIDTH_IN, WIDTH_Q)+1 is the internal dividend/divisor width.
- FSM IDLE -> DIV -> OUT -> IDLE. Only one coefficient is in flight.
- IDLE: in_ready=1. On in_valid&in_ready (cycle k), latch:
  - sign = in_data[MSB];
  - magnitude mag = |in_data|, with -2^(WIDTH_IN-1) yielding 2^(WIDTH_IN-1) without overflow at DW bits;
  - Q = quant_flat entry[index], where Q==0 is substituted by 1;
  - dividend = mag + (Q>>1).
  Go to DIV.
- DIV: in_ready=0. Restoring division, one quotient bit per cycle, MSB first, exactly DW cycles.
- OUT entry:
  - quotient q is negated if sign=1; a zero result stays 0;
  - q is saturated to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1];
  - out_data, out_index=index, and out_last=(index==63) are registered.
  - out_valid first high in cycle k+DW+1.
- OUT: out_valid, out_data, out_index, and out_last hold stable until out_ready=1.
  - On out_valid&out_ready: out_valid=0, index=index+1 mod 64 (63 wraps to 0), state=IDLE, in_ready=1 the next cycle.
- Throughput: one coefficient per DW+2 cycles with out_ready held high.
- in_ready is low in DIV and OUT. in_valid is ignored outside IDLE; no input is lost, because the source must hold in_valid under the handshake.
- quant_flat is sampled only at acceptance. Changes during DIV/OUT do not affect the in-flight result.
- No partial-block abort exists. rst is the only way to realign index to 0.

Test Plan:
- Rounding, WIDTH_OUT=16, index 0, Q0=16: inputs 100, -100, 8, -8, 7 -> out_data 6, -6, 1, -1, 0; each out_valid rises 18 cycles after acceptance (DW=17).
- Q==0 and extremes: Q0=0, in=-32768 -> out=-32768. Q0=1, in=32767 -> 32767. Q0=65535, in=32767 -> 0. Q0=65535, in=-32768 -> -1 (rounding: (32768+32767)/65535=1).
- Saturation: WIDTH_OUT=8, Q0=1, in=1000 -> 127; in=-1000 -> -128.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_data/out_index stable, in_ready=0, in_valid pulses ignored; the first in_valid after release is accepted with index+1.
- Block wrap: stream 64 coefficients with Q[i]=i+1, in=(i+1)*10. Required: out_data=10 for all 64 outputs, out_last only on index 63. The 65th coefficient uses Q[0] with out_index=0.
- Reset mid-DIV: assert rst 5 cycles after acceptance. Required: out_valid=0 and in_ready=1 immediately (asynchronous), index=0, no stale result after release; the next coefficient quantizes with Q[0].

Source files
------------

// File: rtl/jpeg_quant.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quant
// Purpose  : JPEG encoder quantizer. Divides each signed DCT coefficient by its
//            quant-table entry, rounding half away from zero, using a serial
//            restoring divider. The result saturates to the output width.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_quant #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_Q   = 16,
    parameter int WIDTH_OUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH_Q*64-1:0]  quant_flat,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_IN-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_OUT-1:0]   out_data,
    output logic [5:0]             out_index,
    output logic                   out_last
);

    localparam int DW   = ((WIDTH_IN > WIDTH_Q) ? WIDTH_IN : WIDTH_Q) + 1;
    localparam int CW   = ((DW > WIDTH_OUT) ? DW : WIDTH_OUT) + 1;
    localparam int CNTW = $clog2(DW);

    localparam logic [CNTW-1:0]      c_CNT_LAST = CNTW'(DW - 1);
    localparam logic [CW-1:0]        c_POS_MAX  = {{(CW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [CW-1:0]        c_NEG_MAG  = {{(CW-WIDTH_OUT){1'b0}}, 1'b1, {(WIDTH_OUT-1){1'b0}}};
    localparam logic [WIDTH_OUT-1:0] c_OUT_MAX  = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] c_OUT_MIN  = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           index_q, index_d;
    logic                 sign_q, sign_d;
    logic [DW-1:0]        dvd_q, dvd_d;
    logic [DW-1:0]        dvs_q, dvs_d;
    logic [DW-1:0]        rem_q, rem_d;
    logic [DW-1:0]        quot_q, quot_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [5:0]           out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;

    // Acceptance datapath: magnitude, rounded dividend and zero-safe divisor
    logic                 w_sign;
    logic [DW-1:0]        w_in_ext, w_mag, w_divisor, w_dividend;
    logic [WIDTH_Q-1:0]   w_q_raw, w_q_eff;

    assign w_sign     = in_data[WIDTH_IN-1];
    assign w_in_ext   = {{(DW-WIDTH_IN){w_sign}}, in_data};
    assign w_mag      = w_sign ? (DW'(0) - w_in_ext) : w_in_ext;
    assign w_q_raw    = quant_flat[index_q*WIDTH_Q +: WIDTH_Q];
    assign w_q_eff    = (w_q_raw == '0) ? WIDTH_Q'(1) : w_q_raw;
    assign w_divisor  = {{(DW-WIDTH_Q){1'b0}}, w_q_eff};
    assign w_dividend = w_mag + (w_divisor >> 1);

    // One restoring step; no borrow means the divisor fits and the bit is 1
    logic [DW:0]          w_rem_sh, w_diff;
    logic                 w_bit;
    logic [DW-1:0]        w_quot;
    logic [CW-1:0]        w_qext, w_qneg;
    logic [WIDTH_OUT-1:0] w_sat;

    assign w_rem_sh = {rem_q, dvd_q[DW-1]};
    assign w_diff   = w_rem_sh - {1'b0, dvs_q};
    assign w_bit    = ~w_diff[DW];
    assign w_quot   = {quot_q[DW-2:0], w_bit};
    assign w_qext   = {{(CW-DW){1'b0}}, w_quot};
    assign w_qneg   = CW'(0) - w_qext;

    always_comb begin
        w_sat = w_qext[WIDTH_OUT-1:0];
        if (!sign_q) begin
            if (w_qext > c_POS_MAX) w_sat = c_OUT_MAX;
        end else begin
            w_sat = w_qneg[WIDTH_OUT-1:0];
            if (w_qext > c_NEG_MAG) w_sat = c_OUT_MIN;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        sign_d      = sign_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = w_sign;
                    dvd_d   = w_dividend;
                    dvs_d   = w_divisor;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d  = w_bit ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
                quot_d = w_quot;
                dvd_d  = {dvd_q[DW-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                // Last bit: register the signed, saturated result on this edge
                if (cnt_q == c_CNT_LAST) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_sat;
                    out_index_d = index_q;
                    out_last_d  = (index_q == 6'd63);
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    index_d     = index_q + 6'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            sign_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            sign_q      <= sign_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quant.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_quant
// Purpose  : Directed self-checking bench for jpeg_quant (16-bit and 8-bit out).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_quant;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1023:0] quant_flat = '0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, out_last;
    logic [15:0]   out_data;
    logic [5:0]    out_index;
    logic          in_ready8, out_valid8, out_last8;
    logic [7:0]    out_data8;
    logic [5:0]    out_index8;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] cap_data;
    logic [7:0]  cap_data8;
    logic [5:0]  cap_idx;
    logic        cap_last;
    int          cap_lat;

    always #5 clk = ~clk;

    jpeg_quant #(.WIDTH_IN(16), .WIDTH_Q(16), .WIDTH_OUT(16)) dut (
        .clk(clk), .rst(rst), .quant_flat(quant_flat),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    jpeg_quant #(.WIDTH_IN(16), .WIDTH_Q(16), .WIDTH_OUT(8)) dut8 (
        .clk(clk), .rst(rst), .quant_flat(quant_flat),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(1'b1), .out_data(out_data8),
        .out_index(out_index8), .out_last(out_last8)
    );

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_q_all(input logic [15:0] v);
        for (int i = 0; i < 64; i++) quant_flat[i*16 +: 16] = v;
    endtask

    // Drive one coefficient and capture the result; cap_lat counts cycles
    // from acceptance to the first cycle with out_valid high.
    task automatic xfer(input logic [15:0] d);
        int n;
        @(negedge clk);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        cap_lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cap_lat++;
        end while (!out_valid && cap_lat < 200);
        cap_data = out_data; cap_data8 = out_data8;
        cap_idx = out_index; cap_last = out_last;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_data !== 16'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests_run++;
        if (out_index !== 6'd0 || out_last !== 1'b0) begin
            tests_failed++; $display("FAIL reset_index_last got %0d/%b want 0/0", out_index, out_last);
        end
        rst = 1'b0;
    endtask

    task automatic test_rounding();
        logic [15:0] vin [5] = '{16'd100, -16'sd100, 16'd8, -16'sd8, 16'd7};
        logic [15:0] vex [5] = '{16'd6, -16'sd6, 16'd1, -16'sd1, 16'd0};
        do_reset();
        set_q_all(16'd16);
        for (int i = 0; i < 5; i++) begin
            xfer(vin[i]);
            tests_run++;
            if (cap_data !== vex[i] || cap_idx !== 6'(i)) begin
                tests_failed++;
                $display("FAIL rounding[%0d] got %0d idx %0d want %0d idx %0d",
                         i, $signed(cap_data), cap_idx, $signed(vex[i]), i);
            end
            tests_run++;
            if (cap_lat != 18) begin tests_failed++; $display("FAIL latency[%0d] got %0d want 18", i, cap_lat); end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] vq  [4] = '{16'd0, 16'd1, 16'd65535, 16'd65535};
        logic [15:0] vin [4] = '{16'h8000, 16'h7fff, 16'h7fff, 16'h8000};
        logic [15:0] vex [4] = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            set_q_all(vq[i]);
            xfer(vin[i]);
            tests_run++;
            if (cap_data !== vex[i]) begin
                tests_failed++;
                $display("FAIL extreme[%0d] got %h want %h", i, cap_data, vex[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_q_all(16'd1);
        xfer(16'd1000);
        tests_run++;
        if (cap_data8 !== 8'h7f || cap_data !== 16'd1000) begin
            tests_failed++; $display("FAIL sat_pos got %h/%h want 7f/03e8", cap_data8, cap_data);
        end
        xfer(-16'sd1000);
        tests_run++;
        if (cap_data8 !== 8'h80 || cap_data !== 16'hfc18) begin
            tests_failed++; $display("FAIL sat_neg got %h/%h want 80/fc18", cap_data8, cap_data);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        set_q_all(16'd16);
        @(negedge clk);
        in_data = 16'd100; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); in_valid = 1'b0; n++; end while (!out_valid && n < 200);
        for (int j = 0; j < 10; j++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 16'd6 || out_index !== 6'd0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold[%0d] got v=%b d=%0d i=%0d rdy=%b want 1/6/0/0",
                         j, out_valid, out_data, out_index, in_ready);
            end
            in_valid = (j % 2 == 0);
            in_data  = 16'd50;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL release got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        xfer(16'd32);
        tests_run++;
        if (cap_data !== 16'd2 || cap_idx !== 6'd1) begin
            tests_failed++; $display("FAIL after_release got %0d idx %0d want 2 idx 1", cap_data, cap_idx);
        end
    endtask

    task automatic test_block_wrap();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 64; i++) quant_flat[i*16 +: 16] = 16'(i + 1);
        for (int i = 0; i < 64; i++) begin
            xfer(16'((i + 1) * 10));
            tests_run++;
            if (cap_data !== 16'd10 || cap_idx !== 6'(i) || cap_last !== (i == 63) || cap_lat != 18) begin
                tests_failed++;
                if (bad < 5)
                    $display("FAIL wrap[%0d] got d=%0d i=%0d last=%b lat=%0d want 10/%0d/%b/18",
                             i, cap_data, cap_idx, cap_last, cap_lat, i, (i == 63));
                bad++;
            end
        end
        xfer(-16'sd30);
        tests_run++;
        if (cap_data !== -16'sd30 || cap_idx !== 6'd0 || cap_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_65th got d=%0d i=%0d last=%b want -30/0/0", $signed(cap_data), cap_idx, cap_last);
        end
    endtask

    task automatic test_reset_mid_div();
        logic stale = 1'b0;
        do_reset();
        set_q_all(16'd16);
        quant_flat[15:0] = 16'd4;
        xfer(16'd64);
        tests_run++;
        if (cap_data !== 16'd16 || cap_idx !== 6'd0) begin
            tests_failed++; $display("FAIL middiv_pre got %0d idx %0d want 16 idx 0", cap_data, cap_idx);
        end
        @(negedge clk);
        in_data = 16'd100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 6'd0) begin
            tests_failed++;
            $display("FAIL async_rst got v=%b rdy=%b i=%0d want 0/1/0", out_valid, in_ready, out_index);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin @(negedge clk); if (out_valid) stale = 1'b1; end
        tests_run++;
        if (stale !== 1'b0) begin tests_failed++; $display("FAIL stale_result got %b want 0", stale); end
        xfer(16'd100);
        tests_run++;
        if (cap_data !== 16'd25 || cap_idx !== 6'd0) begin
            tests_failed++; $display("FAIL middiv_post got %0d idx %0d want 25 idx 0", cap_data, cap_idx);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_extremes();
        test_saturation();
        test_backpressure();
        test_block_wrap();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
